// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store controller: access sizes and FSM states.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store replication and enables, load lane extract and
// extension, and misalignment detection. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        zext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [31:0] shifted_s;

  // Store side: byte enables and lane-replicated write data
  always_comb begin
    be         = 4'b0000;
    wdata_lane = 32'h0000_0000;
    case (size)
      SZ_BYTE: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        be         = 4'b1111;
        wdata_lane = wdata;
      end
      default: begin
        be         = 4'b0000;
        wdata_lane = 32'h0000_0000;
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend
  always_comb begin
    shifted_s = rdata >> {addr_lo, 3'b000};
    rdata_ext = 32'h0000_0000;
    case (size)
      SZ_BYTE: rdata_ext = zext ? {24'h00_0000, shifted_s[7:0]}
                                : {{24{shifted_s[7]}}, shifted_s[7:0]};
      SZ_HALF: rdata_ext = zext ? {16'h0000, shifted_s[15:0]}
                                : {{16{shifted_s[15]}}, shifted_s[15:0]};
      SZ_WORD: rdata_ext = rdata;
      default: rdata_ext = 32'h0000_0000;
    endcase
  end

  // Size 11 is reserved and always rejected
  always_comb begin
    misaligned = 1'b1;
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr_lo[0];
      SZ_WORD: misaligned = |addr_lo;
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller driving the data-memory interface.
// Optional ISSUE timeout abort is enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              stall_o,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic              mem_ready_i,
  input  logic [31:0]       mem_rdata_i
);
  import lsu_pkg::*;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("lsu_mem_ctrl: TIMEOUT_CYCLES must be >= 1");
  end

  state_e            state_r, state_nxt_s;
  logic              we_r, zext_r, err_r;
  logic [1:0]        size_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r, resp_rdata_r;
  logic              timeout_s, idle_s;
  logic [1:0]        al_size_s, al_addr_s;
  logic              al_zext_s, misaligned_s;
  logic [31:0]       al_wdata_s, lane_wdata_s, rdata_ext_s;
  logic [3:0]        be_s;

  // In IDLE the aligner judges the incoming request; afterwards it works on the held copy
  assign idle_s     = (state_r == ST_IDLE);
  assign al_size_s  = idle_s ? req_size_i      : size_r;
  assign al_addr_s  = idle_s ? req_addr_i[1:0] : addr_r[1:0];
  assign al_zext_s  = idle_s ? req_unsigned_i  : zext_r;
  assign al_wdata_s = idle_s ? req_wdata_i     : wdata_r;

  lsu_align u_align (
    .size       (al_size_s),
    .addr_lo    (al_addr_s),
    .zext       (al_zext_s),
    .wdata      (al_wdata_s),
    .rdata      (mem_rdata_i),
    .be         (be_s),
    .wdata_lane (lane_wdata_s),
    .rdata_ext  (rdata_ext_s),
    .misaligned (misaligned_s)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] wait_cnt_r;

  // Counts ISSUE cycles without ready; parked at zero outside ISSUE
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt_r <= '0;
    end else if (state_r != ST_ISSUE) begin
      wait_cnt_r <= '0;
    end else if (!mem_ready_i) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1'b1);
    end
  end

  // A ready on the last allowed cycle takes priority over the abort
  assign timeout_s = (state_r == ST_ISSUE) && !mem_ready_i &&
                     (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; rejected requests skip ISSUE so no strobe is ever raised
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_nxt_s = misaligned_s ? ST_DONE : ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_ready_i || timeout_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Request capture and response data/error registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_r         <= 1'b0;
      zext_r       <= 1'b0;
      size_r       <= 2'b00;
      addr_r       <= '0;
      wdata_r      <= 32'h0000_0000;
      err_r        <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end else if (idle_s && req_valid_i) begin
      we_r         <= req_we_i;
      zext_r       <= req_unsigned_i;
      size_r       <= req_size_i;
      addr_r       <= req_addr_i;
      wdata_r      <= req_wdata_i;
      err_r        <= misaligned_s;
      resp_rdata_r <= 32'h0000_0000;
    end else if (state_r == ST_ISSUE && mem_ready_i) begin
      err_r        <= 1'b0;
      resp_rdata_r <= we_r ? 32'h0000_0000 : rdata_ext_s;
    end else if (timeout_s) begin
      err_r        <= 1'b1;
      resp_rdata_r <= 32'h0000_0000;
    end
  end

  // Output decode; memory-side fields are only driven while the access is live
  always_comb begin
    stall_o      = 1'b0;
    resp_valid_o = 1'b0;
    err_o        = 1'b0;
    resp_rdata_o = 32'h0000_0000;
    mem_addr_o   = '0;
    mem_wdata_o  = 32'h0000_0000;
    mem_be_o     = 4'b0000;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    case (state_r)
      ST_IDLE: stall_o = req_valid_i & rst_n_i;
      ST_ISSUE: begin
        stall_o     = 1'b1;
        mem_read_o  = ~we_r;
        mem_write_o = we_r;
        mem_addr_o  = {addr_r[ADDR_W-1:2], 2'b00};
        mem_wdata_o = lane_wdata_s;
        mem_be_o    = be_s;
      end
      ST_DONE: begin
        resp_valid_o = 1'b1;
        err_o        = err_r;
        resp_rdata_o = resp_rdata_r;
      end
      default: stall_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed cases plus randomized accesses against
// an arithmetic reference model of alignment, lane steering and load extension.
module tb_lsu_mem_ctrl;
  localparam int ADDR_W = 32;
`ifdef LSU_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_we, req_uns, mem_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic        stall_o, resp_valid_o, err_o, mem_read_o, mem_write_o;
  logic [31:0] resp_rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .stall_o(stall_o), .resp_valid_o(resp_valid_o),
    .resp_rdata_o(resp_rdata_o), .err_o(err_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
  );

  function automatic logic mis_f(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [3:0] be_f(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0:    return 4'b0001 << a[1:0];
      2'd1:    return 4'b0011 << a[1:0];
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wd_f(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0:    return {24'h0, d[7:0]} * 32'h0101_0101;
      2'd1:    return {16'h0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ld_f(input logic [1:0] sz, input logic [31:0] a,
                                       input logic uns, input logic [31:0] r);
    int nb;
    logic [31:0] mask, v;
    nb = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
    mask = (nb == 32) ? 32'hFFFF_FFFF : ((32'h1 << nb) - 32'h1);
    v = (r >> (8 * a[1:0])) & mask;
    if (!uns && nb < 32 && v[nb-1]) v = v | ~mask;
    return v;
  endfunction

  // One access from request to response; ends at the negedge of the response cycle.
  task automatic run_access(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] d, input logic [31:0] r,
                            input int waits, input logic [31:0] exp_rd, input string tag);
    logic m;
    m = mis_f(sz, a);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_uns = uns; req_addr = a; req_wdata = d;
    #1;
    checks++;
    if ({stall_o, resp_valid_o} !== 2'b10) begin
      fails++; $display("FAIL %s req_cycle stall/resp got %b exp 10", tag, {stall_o, resp_valid_o});
    end
    @(negedge clk);
    req_valid = 1'b0;
    if (!m) begin
      for (int w = 0; w <= waits; w++) begin
        checks++;
        if ({stall_o, resp_valid_o, mem_read_o, mem_write_o, mem_be_o} !== {1'b1, 1'b0, !we, we, be_f(sz, a)}) begin
          fails++; $display("FAIL %s issue_ctrl w=%0d got %b exp %b", tag, w,
            {stall_o, resp_valid_o, mem_read_o, mem_write_o, mem_be_o}, {1'b1, 1'b0, !we, we, be_f(sz, a)});
        end
        checks++;
        if (mem_addr_o !== {a[31:2], 2'b00}) begin
          fails++; $display("FAIL %s issue_addr got %h exp %h", tag, mem_addr_o, {a[31:2], 2'b00});
        end
        if (we) begin
          checks++;
          if (mem_wdata_o !== wd_f(sz, d)) begin
            fails++; $display("FAIL %s issue_wdata got %h exp %h", tag, mem_wdata_o, wd_f(sz, d));
          end
        end
        mem_ready = (w == waits);
        mem_rdata = (w == waits) ? r : $urandom;
        @(negedge clk);
        mem_ready = 1'b0;
      end
    end
    checks++;
    if ({stall_o, resp_valid_o, err_o, mem_read_o, mem_write_o} !== {1'b0, 1'b1, m, 1'b0, 1'b0}) begin
      fails++; $display("FAIL %s resp_ctrl got %b exp %b", tag,
        {stall_o, resp_valid_o, err_o, mem_read_o, mem_write_o}, {1'b0, 1'b1, m, 1'b0, 1'b0});
    end
    checks++;
    if (resp_rdata_o !== exp_rd) begin
      fails++; $display("FAIL %s resp_rdata got %h exp %h", tag, resp_rdata_o, exp_rd);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_uns = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({stall_o, resp_valid_o, err_o, resp_rdata_o, mem_addr_o, mem_wdata_o, mem_be_o,
         mem_read_o, mem_write_o} !== '0) begin
      fails++; $display("FAIL reset_outputs got %h exp 0", {stall_o, resp_valid_o, err_o,
        resp_rdata_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_read_o, mem_write_o});
    end
    rst_n = 1'b1;
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({resp_valid_o, stall_o, mem_read_o, mem_write_o} !== 4'b0000) begin
        fails++; $display("FAIL idle_ready_ignored got %b exp 0000",
          {resp_valid_o, stall_o, mem_read_o, mem_write_o});
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_directed;
    run_access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 32'h0, "store_word");
    run_access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h80FF_FFFF, 0, 32'hFFFF_FF80, "load_byte_s");
    run_access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h80FF_FFFF, 0, 32'h0000_0080, "load_byte_u");
    run_access(1'b0, 2'd1, 1'b0, 32'h02, 32'h0, 32'hBEEF_0000, 3, 32'hFFFF_BEEF, "load_half_wait");
    run_access(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 32'h1234_5678, 0, 32'h0, "mis_word");
    run_access(1'b1, 2'd3, 1'b0, 32'h08, 32'h55AA_55AA, 32'h0, 0, 32'h0, "rsvd_size");
    run_access(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_C3A5, 32'h0, 1, 32'h0, "store_half_hi");
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h20;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (mem_read_o !== 1'b1) begin
      fails++; $display("FAIL mid_rst_pre_read got %b exp 1", mem_read_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_read_o, mem_write_o, stall_o} !== 3'b000) begin
      fails++; $display("FAIL mid_rst_strobes got %b exp 000", {mem_read_o, mem_write_o, stall_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({resp_valid_o, stall_o, mem_read_o} !== 3'b000) begin
        fails++; $display("FAIL mid_rst_after got %b exp 000", {resp_valid_o, stall_o, mem_read_o});
      end
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < TO; i++) begin
      checks++;
      if ({mem_read_o, stall_o, resp_valid_o} !== 3'b110) begin
        fails++; $display("FAIL timeout_issue c=%0d got %b exp 110", i, {mem_read_o, stall_o, resp_valid_o});
      end
      @(negedge clk);
    end
    checks++;
    if ({resp_valid_o, err_o, mem_read_o, resp_rdata_o} !== {3'b110, 32'h0}) begin
      fails++; $display("FAIL timeout_resp got %h exp %h", {resp_valid_o, err_o, mem_read_o, resp_rdata_o}, {3'b110, 32'h0});
    end
  endtask
`else
  task automatic test_long_wait;
    run_access(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 32'hCAFE_F00D, 20, 32'hCAFE_F00D, "long_wait");
  endtask
`endif

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic we_v, uns_v;
      logic [1:0] sz;
      logic [31:0] a, d, r, e;
      int wt;
      we_v = 1'($urandom_range(0, 1));
      uns_v = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a = $urandom; d = $urandom; r = $urandom;
      wt = $urandom_range(0, 3);
      e = (we_v || mis_f(sz, a)) ? 32'h0 : ld_f(sz, a, uns_v, r);
      run_access(we_v, sz, uns_v, a, d, r, wt, e, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_access();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_random();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
